// File: rtl/precharge_pkg.sv
// Shared constants and state encoding for the bitline precharge sequencer.
// Supply/threshold levels are modelled as reals.
package precharge_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_EQ   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/precharge_timer.sv
// Phase counter: load a start value, count down to zero, flag zero.
// Holds at zero until reloaded.
module precharge_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/precharge_seq.sv
// Bitline precharge sequencer: IDLE -> PRE [-> EQ] -> HOLD.
// Optional equalize phase enabled by macro PRECHARGE_EQ_EN.
module precharge_seq
    import precharge_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int PRE_CYCLES = 4,
    parameter int EQ_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  real             rd_wr,
    input  logic            start,
    input  logic [COLS-1:0] col_en,
    output real             bl_rd  [0:COLS-1],
    output real             blb_rd [0:COLS-1],
    output logic            busy,
    output logic            ready,
`ifdef PRECHARGE_EQ_EN
    output logic            eq,
`endif
    output logic            done
);

    localparam int CW = $clog2(max2(PRE_CYCLES, EQ_CYCLES) + 1);

    state_e          state_q, state_d;
    logic [COLS-1:0] mask_q, mask_d;
    logic            done_q, done_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_zero;
    logic            l_rw;

    assign l_rw = (rd_wr >= VTH);

    precharge_timer #(
        .W(CW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(tmr_load),
        .val_i (tmr_val),
        .zero_o(tmr_zero)
    );

    // Dropping rd_wr aborts any phase, even on the counter's last cycle
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && l_rw) begin
                    state_d  = ST_PRE;
                    mask_d   = col_en;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(PRE_CYCLES - 1);
                end
            end
            ST_PRE: begin
                if (!l_rw) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
`ifdef PRECHARGE_EQ_EN
                    state_d  = ST_EQ;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(EQ_CYCLES - 1);
`else
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PRECHARGE_EQ_EN
            ST_EQ: begin
                if (!l_rw) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_HOLD: begin
                if (!l_rw) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == ST_PRE) || (state_q == ST_EQ);
    assign ready = (state_q == ST_HOLD);
    assign done  = done_q;
`ifdef PRECHARGE_EQ_EN
    assign eq    = (state_q == ST_EQ);
`endif

    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            if ((state_q != ST_IDLE) && mask_q[i]) begin
                bl_rd[i]  = VDD;
                blb_rd[i] = VDD;
            end else begin
                bl_rd[i]  = VSS;
                blb_rd[i] = VSS;
            end
        end
    end

endmodule

// File: tb/tb_precharge_seq.sv
// Directed scoreboard bench for precharge_seq (COLS=8, PRE_CYCLES=3).
// Expected cycle results are queued at drive time and popped after each edge.
module tb_precharge_seq;

    logic       clk;
    logic       rst_n;
    real        rd_wr;
    logic       start;
    logic [7:0] col_en;
    real        bl_rd  [0:7];
    real        blb_rd [0:7];
    logic       busy;
    logic       ready;
    logic       done;
`ifdef PRECHARGE_EQ_EN
    logic       eq;
`endif

    typedef struct packed {
        logic       busy;
        logic       ready;
        logic       done;
        logic       eq;
        logic [7:0] bl;
        logic [7:0] blb;
        logic       bad;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    precharge_seq #(
        .COLS      (8),
        .PRE_CYCLES(3),
        .EQ_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_wr (rd_wr),
        .start (start),
        .col_en(col_en),
        .bl_rd (bl_rd),
        .blb_rd(blb_rd),
        .busy  (busy),
        .ready (ready),
`ifdef PRECHARGE_EQ_EN
        .eq    (eq),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic obs_t observe();
        obs_t o;
        o = '0;
        o.busy  = busy;
        o.ready = ready;
        o.done  = done;
`ifdef PRECHARGE_EQ_EN
        o.eq    = eq;
`endif
        for (int i = 0; i < 8; i++) begin
            o.bl[i]  = (bl_rd[i] == 1.5);
            o.blb[i] = (blb_rd[i] == 1.5);
            if (!(bl_rd[i] == 1.5 || bl_rd[i] == 0.0))
                o.bad = 1'b1;
            if (!(blb_rd[i] == 1.5 || blb_rd[i] == 0.0))
                o.bad = 1'b1;
        end
        return o;
    endfunction

    task automatic push(input logic b, input logic r, input logic d,
                        input logic e, input logic [7:0] m);
        obs_t x;
        x = '{busy: b, ready: r, done: d, eq: e, bl: m, blb: m, bad: 1'b0};
        exp_q.push_back(x);
    endtask

    task automatic chk(input string tag);
        obs_t e;
        obs_t o;
        e = exp_q.pop_front();
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: queue expectation, advance, sample 1ns after the edge
    task automatic cyc(input string tag, input logic b, input logic r,
                       input logic d, input logic e, input logic [7:0] m);
        push(b, r, d, e, m);
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    task automatic now(input string tag, input logic b, input logic r,
                       input logic d, input logic e, input logic [7:0] m);
        push(b, r, d, e, m);
        chk(tag);
    endtask

    task automatic eq_phase(input string tag, input logic [7:0] m);
`ifdef PRECHARGE_EQ_EN
        cyc({tag, "_eq1"}, 1, 0, 0, 1, m);
        cyc({tag, "_eq2"}, 1, 0, 0, 1, m);
`else
        if (m === 8'hxx) $display("unreachable %s", tag);
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        col_en = 8'h00;
        rd_wr  = 0.0;
        #2;
        now("reset", 0, 0, 0, 0, 8'h00);

        // First start right after reset release, mask A5
        #1;
        rst_n  = 1'b1;
        rd_wr  = 1.5;
        col_en = 8'hA5;
        start  = 1'b1;
        cyc("pre1", 1, 0, 0, 0, 8'hA5);
        start = 1'b0;
        cyc("pre2", 1, 0, 0, 0, 8'hA5);
        start  = 1'b1;
        col_en = 8'hFF;
        cyc("pre3_ign", 1, 0, 0, 0, 8'hA5);
        start  = 1'b0;
        eq_phase("a", 8'hA5);
        cyc("done", 0, 1, 1, 0, 8'hA5);
        cyc("hold", 0, 1, 0, 0, 8'hA5);
        rd_wr = 0.0;
        cyc("hold_exit", 0, 0, 0, 0, 8'h00);

        // Low request level ignores start
        rd_wr  = 0.5;
        start  = 1'b1;
        col_en = 8'hFF;
        cyc("lowrw1", 0, 0, 0, 0, 8'h00);
        cyc("lowrw2", 0, 0, 0, 0, 8'h00);
        start = 1'b0;

        // Abort in PRE cycle 2
        rd_wr  = 1.5;
        start  = 1'b1;
        col_en = 8'h3C;
        cyc("ab_pre1", 1, 0, 0, 0, 8'h3C);
        start = 1'b0;
        cyc("ab_pre2", 1, 0, 0, 0, 8'h3C);
        rd_wr = 0.0;
        cyc("ab_idle1", 0, 0, 0, 0, 8'h00);
        cyc("ab_idle2", 0, 0, 0, 0, 8'h00);

        // Abort coinciding with counter expiry
        rd_wr  = 1.5;
        start  = 1'b1;
        col_en = 8'h81;
        cyc("ex_pre1", 1, 0, 0, 0, 8'h81);
        start = 1'b0;
        cyc("ex_pre2", 1, 0, 0, 0, 8'h81);
        cyc("ex_pre3", 1, 0, 0, 0, 8'h81);
        rd_wr = 0.0;
        cyc("ex_idle", 0, 0, 0, 0, 8'h00);

        // Asynchronous reset while in HOLD
        rd_wr  = 1.5;
        start  = 1'b1;
        col_en = 8'h0F;
        cyc("rh_pre1", 1, 0, 0, 0, 8'h0F);
        start = 1'b0;
        cyc("rh_pre2", 1, 0, 0, 0, 8'h0F);
        cyc("rh_pre3", 1, 0, 0, 0, 8'h0F);
        eq_phase("rh", 8'h0F);
        cyc("rh_done", 0, 1, 1, 0, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        now("rst_hold", 0, 0, 0, 0, 8'h00);
        rst_n  = 1'b1;
        start  = 1'b1;
        col_en = 8'hF0;
        cyc("post_rst", 1, 0, 0, 0, 8'hF0);
        start = 1'b0;
        rd_wr = 0.0;
        cyc("post_idle", 0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
